rect_fill: RTL and testbench
============================

RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 SCREEN_W, 640, visible width in pixels; sets the x clip bound.
REQ-002 SCREEN_H, 480, visible height in pixels; sets the y clip bound.
REQ-003 clk  input  1  sole clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  draw command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_x0, cmd_y0  input  16 each  top-left corner, inclusive.
REQ-008 cmd_x1, cmd_y1  input  16 each  bottom-right corner, inclusive.
REQ-009 cmd_color  input  9  fill colour, {r[2:0], g[2:0], b[2:0]}.
REQ-010 wr_en  output  1  framebuffer write request.
REQ-011 wr_ready  input  1  framebuffer accepts the write this cycle.
REQ-012 wr_addr  output  32  pixel address {y[15:0], x[15:0]}, same packing as the display scan address.
REQ-013 wr_data  output  9  pixel colour written.
REQ-014 busy  output  1  a command is in progress.
REQ-015 done  output  1  one-cycle pulse at command completion.

Function
REQ-016 States: IDLE and FILL. cmd_ready = 1 only in IDLE; busy = 1 only in FILL.
REQ-017 A command is accepted on a clock edge where cmd_valid && cmd_ready. All command fields latch on that edge; later input changes have no effect.
REQ-018 Empty command (x0 > x1 or y0 > y1, after clipping when enabled): no write is issued, the state stays IDLE, and done pulses in the cycle after acceptance.
REQ-019 Non-empty command: the state moves to FILL. The first wr_en is in the cycle after acceptance, at (x0, y0).
REQ-020 Scan is raster order: x runs x0..x1; at x == x1, x returns to x0 and y increments; y runs y0..y1.
REQ-021 In FILL, wr_en = 1, wr_data = latched colour, and wr_addr = current {y, x}.
REQ-022 A write completes on an edge with wr_en && wr_ready. If wr_ready = 0, wr_addr and wr_data hold and the scan does not advance.
REQ-023 After the write at (x1, y1) completes, the state returns to IDLE. On the next cycle wr_en = 0, done = 1 and cmd_ready = 1.
REQ-024 A command may be accepted in the same cycle done is high.
REQ-025 With wr_ready tied to 1, a W×H rectangle takes exactly W*H write cycles, and done asserts W*H+1 cycles after acceptance.
REQ-026 End-of-row and end-of-rectangle detection use equality compares on 16-bit counters. x1 or y1 = 16'hFFFF completes without wrap or overrun.
REQ-027 Single-pixel command (x0 = x1, y0 = y1) produces exactly one write.

Reset
REQ-028 rst low forces, asynchronously: state IDLE, wr_en = 0, done = 0, busy = 0, wr_addr = 0, wr_data = 0, all counters and latched fields = 0.
REQ-029 Reset during FILL aborts the command immediately. No further writes and no done pulse for the aborted command.
REQ-030 cmd_ready = 1 from the first clock edge after rst returns high.

Configuration
REQ-031 Macro RECT_FILL_CLIP_EN.
- Defined: at acceptance, x1 clamps to min(x1, SCREEN_W-1) and y1 clamps to min(y1, SCREEN_H-1). A command with x0 >= SCREEN_W or y0 >= SCREEN_H is treated as empty (REQ-018).
- Undefined: coordinates are used unmodified, and off-screen addresses are written.

Verification
REQ-032 Reset, then command (2,3)-(4,4) colour 9'h1C0, wr_ready = 1:
- six writes in order {3,2},{3,3},{3,4},{4,2},{4,3},{4,4}, all data 9'h1C0;
- done 7 cycles after acceptance.
REQ-033 Command (0,0)-(1,0), wr_ready low for 3 cycles during the first write -> addr {0,0} held 4 cycles, then {0,1}, then done.
REQ-034 Command x0 = 5, x1 = 4 -> zero writes, done the cycle after acceptance, cmd_ready stays 1.
REQ-035 With RECT_FILL_CLIP_EN, command (638,478)-(700,600) -> writes only {478,638},{478,639},{479,638},{479,639}. With x0 = 640 -> zero writes.
REQ-036 rst pulled low mid-FILL -> wr_en = 0 without waiting for a clock edge, no done. First command after release starts cleanly at its own x0, y0.
REQ-037 Back-to-back: second command with cmd_valid held high is accepted in the done cycle of the first -> its first write follows with no idle gap.

Source files
------------

// File: rtl/rect_fill.sv
// rect_fill: fills an inclusive rectangle in raster order, one {y,x}-addressed pixel write per accepted cycle.
// Define RECT_FILL_CLIP_EN to clamp commands to the SCREEN_W x SCREEN_H visible area.
module rect_fill #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_x0,
    input  logic [15:0] cmd_y0,
    input  logic [15:0] cmd_x1,
    input  logic [15:0] cmd_y1,
    input  logic [8:0]  cmd_color,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [8:0]  wr_data,
    output logic        busy,
    output logic        done
);

`ifdef RECT_FILL_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
    localparam logic [15:0] Y_MAX = 16'(SCREEN_H - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_x0;
    logic [15:0] r_x1;
    logic [15:0] r_y1;
    logic [8:0]  r_color;
    logic        r_done;
    logic        w_done_nxt;
    logic [15:0] w_x1_eff;
    logic [15:0] w_y1_eff;
    logic        w_offscreen;
    logic        w_empty;
    logic        w_accept;
    logic        w_wr_fire;
    logic        w_row_end;
    logic        w_last;

    // Clamp happens on the command inputs so the empty test sees the clipped extent.
    always_comb begin
        w_x1_eff    = cmd_x1;
        w_y1_eff    = cmd_y1;
        w_offscreen = 1'b0;
        if (CLIP_EN) begin
            w_x1_eff    = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
            w_y1_eff    = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
            w_offscreen = (cmd_x0 > X_MAX) || (cmd_y0 > Y_MAX);
        end
        w_empty = w_offscreen || (cmd_x0 > w_x1_eff) || (cmd_y0 > w_y1_eff);
    end

    assign w_accept  = cmd_valid && (r_state == IDLE);
    assign w_wr_fire = (r_state == FILL) && wr_ready;
    assign w_row_end = (r_x == r_x1);
    assign w_last    = w_row_end && (r_y == r_y1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (w_empty) w_done_nxt  = 1'b1;
                    else         w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (wr_ready && w_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters only step while not on the last pixel, so x1/y1 = 16'hFFFF never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_color <= '0;
        end else if (w_accept) begin
            r_x     <= cmd_x0;
            r_y     <= cmd_y0;
            r_x0    <= cmd_x0;
            r_x1    <= w_x1_eff;
            r_y1    <= w_y1_eff;
            r_color <= cmd_color;
        end else if (w_wr_fire && !w_last) begin
            if (w_row_end) begin
                r_x <= r_x0;
                r_y <= r_y + 16'd1;
            end else begin
                r_x <= r_x + 16'd1;
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state == FILL);
    assign wr_en     = (r_state == FILL);
    assign wr_addr   = {r_y, r_x};
    assign wr_data   = r_color;
    assign done      = r_done;

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: scoreboard of expected {addr,data} writes plus per-scenario timing checks.
module tb_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_x0 = '0;
    logic [15:0] cmd_y0 = '0;
    logic [15:0] cmd_x1 = '0;
    logic [15:0] cmd_y1 = '0;
    logic [8:0]  cmd_color = '0;
    logic        wr_en;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr;
    logic [8:0]  wr_data;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int writes = 0;
    logic [40:0] exp_q[$];

    rect_fill #(.SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted write is popped and compared in order.
    always @(negedge clk) begin
        logic [40:0] e;
        if (rst && wr_en && wr_ready) begin
            writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected addr=%h data=%h", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    bad++;
                    $display("FAIL write addr=%h data=%h want addr=%h data=%h",
                             wr_addr, wr_data, e[40:9], e[8:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input logic [8:0] c);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                exp_q.push_back({16'(y), 16'(x), c});
    endtask

    // Drives one command; returns #1 after the acceptance edge with fields scrambled.
    task automatic issue(input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1, input logic [8:0] c);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x0 = 16'h1111; cmd_y0 = 16'h2222; cmd_x1 = 16'h0000; cmd_y1 = 16'h0000;
        cmd_color = 9'h0AA;
    endtask

    // Number of cycles after the current point until done is seen; -1 if never.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({wr_en, done, busy, wr_addr, wr_data} !== 44'h0) begin
            bad++;
            $display("FAIL reset_outputs got wr_en=%b done=%b busy=%b addr=%h data=%h want all 0",
                     wr_en, done, busy, wr_addr, wr_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic;
        int k, w0;
        w0 = writes;
        push_rect(2, 3, 4, 4, 9'h1C0);
        issue(16'd2, 16'd3, 16'd4, 16'd4, 9'h1C0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || wr_en !== 1'b1) begin
            bad++;
            $display("FAIL basic_fill_flags got busy=%b ready=%b wr_en=%b want 1 0 1",
                     busy, cmd_ready, wr_en);
        end
        wait_done(k);
        total++;
        if (k + 1 !== 7) begin
            bad++;
            $display("FAIL basic_done_latency got %0d want 7", k + 1);
        end
        total++;
        if (writes - w0 !== 6 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL basic_write_count got %0d left=%0d want 6 left=0",
                     writes - w0, exp_q.size());
        end
    endtask

    task automatic test_stall;
        logic held_ok;
        held_ok = 1'b1;
        push_rect(0, 0, 1, 0, 9'h03F);
        @(posedge clk); #1;
        wr_ready = 1'b0;
        issue(16'd0, 16'd0, 16'd1, 16'd0, 9'h03F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 9'h03F) held_ok = 1'b0;
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        @(negedge clk);
        if (wr_en !== 1'b1 || wr_addr !== 32'h0) held_ok = 1'b0;
        total++;
        if (held_ok !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold got addr=%h wr_en=%b want addr 0 held 4 cycles", wr_addr, wr_en);
        end
        @(negedge clk);
        total++;
        if (wr_addr !== 32'h0000_0001 || wr_en !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL stall_advance got addr=%h wr_en=%b done=%b want 00000001 1 0",
                     wr_addr, wr_en, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || wr_en !== 1'b0 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL stall_done got done=%b wr_en=%b left=%0d want 1 0 0",
                     done, wr_en, exp_q.size());
        end
    endtask

    task automatic test_empty;
        int k, w0;
        w0 = writes;
        issue(16'd5, 16'd0, 16'd4, 16'd0, 9'h155);
        wait_done(k);
        total++;
        if (k !== 1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_x got k=%0d ready=%b busy=%b want 1 1 0", k, cmd_ready, busy);
        end
        issue(16'd0, 16'd9, 16'd3, 16'd8, 9'h155);
        wait_done(k);
        total++;
        if (k !== 1 || writes - w0 !== 0) begin
            bad++;
            $display("FAIL empty_y got k=%0d writes=%0d want 1 0", k, writes - w0);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle got %b want 0", done);
        end
    endtask

    task automatic test_single;
        int k, w0;
        w0 = writes;
        push_rect(7, 9, 7, 9, 9'h007);
        issue(16'd7, 16'd9, 16'd7, 16'd9, 9'h007);
        wait_done(k);
        total++;
        if (k !== 2 || writes - w0 !== 1) begin
            bad++;
            $display("FAIL single_pixel got k=%0d writes=%0d want 2 1", k, writes - w0);
        end
    endtask

    task automatic test_edge;
        int k, w0;
        w0 = writes;
`ifdef RECT_FILL_CLIP_EN
        issue(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 9'h1FF);
        wait_done(k);
        total++;
        if (k !== 1 || writes - w0 !== 0) begin
            bad++;
            $display("FAIL edge_ffff got k=%0d writes=%0d want 1 0", k, writes - w0);
        end
`else
        push_rect(32'hFFFE, 32'hFFFF, 32'hFFFF, 32'hFFFF, 9'h1FF);
        issue(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 9'h1FF);
        wait_done(k);
        total++;
        if (k !== 3 || writes - w0 !== 2 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL edge_ffff got k=%0d writes=%0d want 3 2", k, writes - w0);
        end
`endif
    endtask

    task automatic test_clip;
        int k, w0;
        w0 = writes;
`ifdef RECT_FILL_CLIP_EN
        push_rect(638, 478, 639, 479, 9'h0F0);
        issue(16'd638, 16'd478, 16'd700, 16'd600, 9'h0F0);
        wait_done(k);
        total++;
        if (k !== 5 || writes - w0 !== 4 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL clip_corner got k=%0d writes=%0d want 5 4", k, writes - w0);
        end
        w0 = writes;
        issue(16'd640, 16'd0, 16'd650, 16'd2, 9'h0F0);
        wait_done(k);
        total++;
        if (k !== 1 || writes - w0 !== 0) begin
            bad++;
            $display("FAIL clip_offscreen got k=%0d writes=%0d want 1 0", k, writes - w0);
        end
`else
        push_rect(700, 500, 701, 500, 9'h0F0);
        issue(16'd700, 16'd500, 16'd701, 16'd500, 9'h0F0);
        wait_done(k);
        total++;
        if (k !== 3 || writes - w0 !== 2 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL noclip_offscreen got k=%0d writes=%0d want 3 2", k, writes - w0);
        end
`endif
    endtask

    task automatic test_reset_abort;
        int k, w0;
        logic quiet;
        quiet = 1'b1;
        push_rect(0, 0, 9, 9, 9'h111);
        issue(16'd0, 16'd0, 16'd9, 16'd9, 9'h111);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_async got wr_en=%b busy=%b want 0 0", wr_en, busy);
        end
        exp_q.delete();
        w0 = writes;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || wr_en !== 1'b0) quiet = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || wr_en !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1 || writes - w0 !== 0) begin
            bad++;
            $display("FAIL abort_quiet got quiet=%b writes=%0d want 1 0", quiet, writes - w0);
        end
        push_rect(3, 1, 3, 1, 9'h0C3);
        issue(16'd3, 16'd1, 16'd3, 16'd1, 9'h0C3);
        wait_done(k);
        total++;
        if (k !== 2 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL abort_restart got k=%0d left=%0d want 2 0", k, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int k;
        push_rect(1, 1, 2, 1, 9'h049);
        push_rect(5, 5, 5, 5, 9'h192);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_x0 = 16'd1; cmd_y0 = 16'd1; cmd_x1 = 16'd2; cmd_y1 = 16'd1; cmd_color = 9'h049;
        @(posedge clk); #1;
        cmd_x0 = 16'd5; cmd_y0 = 16'd5; cmd_x1 = 16'd5; cmd_y1 = 16'd5; cmd_color = 9'h192;
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done got done=%b ready=%b want 1 1", done, cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 32'h0005_0005) begin
            bad++;
            $display("FAIL b2b_no_gap got wr_en=%b addr=%h want 1 00050005", wr_en, wr_addr);
        end
        wait_done(k);
        total++;
        if (k !== 1 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_second_done got k=%0d left=%0d want 1 0", k, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_single();
        test_edge();
        test_clip();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
